// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART ALU link (host and device sides).
// - state_t   : host FSM state encoding (3 bits)
// - IDX_*     : position of each request byte on the wire (A first, then B, then op)
// - *_DEF     : default operand / op-code widths used by both ends of the link
package alu_uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_CODE_DEF = 6;

  localparam int IDX_A  = 0;
  localparam int IDX_B  = 1;
  localparam int IDX_OP = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_SEND_B   = 3'd2,
    ST_SEND_OP  = 3'd3,
    ST_WAIT_RES = 3'd4
  } state_t;

endpackage

// File: rtl/alu_uart_host_tmo_counter.sv
// tmo_counter: free-running up counter with synchronous clear, used as the
// WAIT_RES timeout.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : force the count to zero (takes priority over i_enable)
//   i_enable       : increment by one this cycle
//   o_reached      : count currently equals LIMIT-1
module tmo_counter #(
  parameter int NB    = 20,
  parameter int LIMIT = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_reached
);

  logic [NB-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (i_enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_reached = (cnt == NB'(LIMIT - 1));

endmodule

// File: rtl/alu_uart_host.sv
// alu_uart_host: host-side initiator for the UART ALU link.
// Takes one request (A, B, op), pushes it as three bytes into a UART TX FIFO,
// then waits (bounded by TIMEOUT_CYC cycles) for a single result byte from the
// UART RX FIFO and hands it back to the requester.
// Ports:
//   i_clk, i_reset             : clock, synchronous active-high reset
//   i_req_valid / o_req_ready  : request handshake; a request transfers on a
//                                cycle where both are 1. o_req_ready is 1 only
//                                in IDLE; a held request simply waits.
//   i_req_a, i_req_b, i_req_op : request payload
//   o_wr_uart, o_w_data        : TX FIFO push strobe and data
//   i_tx_full                  : TX FIFO full; blocks the push
//   o_rd_uart                  : RX FIFO pop strobe (i_r_data valid while !i_rx_empty)
//   i_r_data, i_rx_empty       : RX FIFO head word and empty flag
//   o_res_valid                : one-cycle pulse, result or timeout available
//   o_result, o_timeout        : result byte (0 on timeout) and timeout flag,
//                                held until the next o_res_valid
//   o_drop_cnt                 : stray RX bytes discarded in IDLE, saturating
//   o_state                    : current FSM state, for observation
module alu_uart_host
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_CODE     = NB_CODE_DEF,
  parameter int NB_TIMEOUT  = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_DATA-1:0] i_req_a,
  input  logic [NB_DATA-1:0] i_req_b,
  input  logic [NB_CODE-1:0] i_req_op,
  output logic               o_wr_uart,
  output logic [NB_DATA-1:0] o_w_data,
  input  logic               i_tx_full,
  output logic               o_rd_uart,
  input  logic [NB_DATA-1:0] i_r_data,
  input  logic               i_rx_empty,
  output logic               o_res_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_timeout,
  output logic [7:0]         o_drop_cnt,
  output state_t             o_state
);

  state_t                  state;
  logic [2:0][NB_DATA-1:0] req_bytes;
  logic                    tmo_hit;
  logic                    in_send;

  // The counter is held at zero outside WAIT_RES, so it starts from 0 on entry.
  tmo_counter #(
    .NB    (NB_TIMEOUT),
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (state != ST_WAIT_RES),
    .i_enable  (state == ST_WAIT_RES),
    .o_reached (tmo_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      req_bytes   <= '0;
      o_res_valid <= 1'b0;
      o_result    <= '0;
      o_timeout   <= 1'b0;
      o_drop_cnt  <= '0;
    end else begin
      o_res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Anything in RX while idle belongs to no request: it is popped
          // (see o_rd_uart) and only counted here.
          if (!i_rx_empty && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
          end
          if (i_req_valid) begin
            req_bytes[IDX_A]  <= i_req_a;
            req_bytes[IDX_B]  <= i_req_b;
            req_bytes[IDX_OP] <= NB_DATA'(i_req_op);
            state             <= ST_SEND_A;
          end
        end
        ST_SEND_A:  if (!i_tx_full) state <= ST_SEND_B;
        ST_SEND_B:  if (!i_tx_full) state <= ST_SEND_OP;
        ST_SEND_OP: if (!i_tx_full) state <= ST_WAIT_RES;
        ST_WAIT_RES: begin
          // Data is checked first so a byte arriving on the last counting
          // cycle is returned rather than reported as a timeout.
          if (!i_rx_empty) begin
            o_result    <= i_r_data;
            o_timeout   <= 1'b0;
            o_res_valid <= 1'b1;
            state       <= ST_IDLE;
          end else if (tmo_hit) begin
            o_result    <= '0;
            o_timeout   <= 1'b1;
            o_res_valid <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_send     = (state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_SEND_OP);
  assign o_req_ready = (state == ST_IDLE);
  assign o_wr_uart   = in_send && !i_tx_full;
  assign o_rd_uart   = ((state == ST_IDLE) || (state == ST_WAIT_RES)) && !i_rx_empty;
  assign o_state     = state;

  always_comb begin
    o_w_data = '0;
    case (state)
      ST_SEND_A:  o_w_data = req_bytes[IDX_A];
      ST_SEND_B:  o_w_data = req_bytes[IDX_B];
      ST_SEND_OP: o_w_data = req_bytes[IDX_OP];
      default:    o_w_data = '0;
    endcase
  end

endmodule
